// File: rtl/branch_predict_table.sv
// Direct-mapped branch prediction table: two registered fetch lookups per cycle,
// one execute-stage update port, and a post-reset sweep that invalidates every entry.
module branch_predict_table #(
    parameter int         PC_W     = 13,
    parameter int         IDX_W    = 11,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [PC_W-1:0]  RD_PC1,
    input  logic [PC_W-1:0]  RD_PC2,
    input  logic             STALL,
    input  logic             W_EN,
    input  logic [IDX_W-1:0] W_ADDR,
    input  logic [15:0]      W_DATA,
    output logic             PRED_TAKEN1,
    output logic [PC_W-1:0]  PRED_TGT1,
    output logic             PRED_TAKEN2,
    output logic [PC_W-1:0]  PRED_TGT2,
    output logic             BUSY
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    // entry layout: [15] valid, [14:13] counter, [12:0] target
    logic [15:0]      r_mem [DEPTH];
    state_t           r_state;
    logic [IDX_W-1:0] r_clr_idx;
    logic             r_busy;
    logic             r_taken1, r_taken2;
    logic [12:0]      r_tgt1, r_tgt2;

    logic [IDX_W-1:0] w_idx1, w_idx2;
    logic [15:0]      w_old, w_upd, w_ent1, w_ent2;
    logic [1:0]       w_cnt;
    logic             w_wr;
    logic             w_unused;

    assign w_idx1   = RD_PC1[IDX_W+1:2];
    assign w_idx2   = RD_PC2[IDX_W+1:2];
    assign w_unused = ^{RD_PC1[1:0], RD_PC2[1:0], W_DATA[13]};
    assign w_old    = r_mem[W_ADDR];
    assign w_cnt    = w_old[14:13];
    assign w_wr     = W_EN && !RST && (r_state == S_READY);

    always_comb begin
        w_upd = w_old;
        if (W_DATA[14]) begin
            w_upd = {1'b1, 2'b11, W_DATA[12:0]};
        end else if (!w_old[15]) begin
            w_upd = W_DATA[15] ? {1'b1, 2'b10, W_DATA[12:0]} : {1'b1, CNT_INIT, 13'd0};
        end else if (W_DATA[15]) begin
            w_upd = {1'b1, (w_cnt == 2'b11) ? 2'b11 : w_cnt + 2'd1, W_DATA[12:0]};
        end else begin
            w_upd = {1'b1, (w_cnt == 2'b00) ? 2'b00 : w_cnt - 2'd1, w_old[12:0]};
        end
    end

    // write-first bypass so a same-cycle update is visible to the lookup
    assign w_ent1 = (w_wr && (W_ADDR == w_idx1)) ? w_upd : r_mem[w_idx1];
    assign w_ent2 = (w_wr && (W_ADDR == w_idx2)) ? w_upd : r_mem[w_idx2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && (r_state == S_CLEAR)) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_wr) begin
            r_mem[W_ADDR] <= w_upd;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || (r_state == S_CLEAR)) begin
            r_taken1 <= 1'b0;
            r_tgt1   <= '0;
            r_taken2 <= 1'b0;
            r_tgt2   <= '0;
        end else if (!STALL) begin
            r_taken1 <= w_ent1[15] & w_ent1[14];
            r_tgt1   <= w_ent1[12:0];
            r_taken2 <= w_ent2[15] & w_ent2[14];
            r_tgt2   <= w_ent2[12:0];
        end
    end

    assign PRED_TAKEN1 = r_taken1;
    assign PRED_TGT1   = PC_W'(r_tgt1);
    assign PRED_TAKEN2 = r_taken2;
    assign PRED_TGT2   = PC_W'(r_tgt2);
    assign BUSY        = r_busy;
endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table: a table-level model checked every cycle,
// plus literal expectations at the scenario checkpoints.
module tb_branch_predict_table;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [12:0] RD_PC1 = '0, RD_PC2 = '0;
    logic        STALL = 1'b0;
    logic        W_EN = 1'b0;
    logic [10:0] W_ADDR = '0;
    logic [15:0] W_DATA = '0;
    logic        PRED_TAKEN1, PRED_TAKEN2, BUSY;
    logic [12:0] PRED_TGT1, PRED_TGT2;

    int checks = 0;
    int errors = 0;

    branch_predict_table dut (
        .CLK(CLK), .RST(RST), .RD_PC1(RD_PC1), .RD_PC2(RD_PC2), .STALL(STALL),
        .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .PRED_TAKEN1(PRED_TAKEN1), .PRED_TGT1(PRED_TGT1),
        .PRED_TAKEN2(PRED_TAKEN2), .PRED_TGT2(PRED_TGT2), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // model: per-entry valid / counter (0..3) / target, a clear countdown and expected outputs
    bit m_valid [2048];
    int m_cnt   [2048];
    int m_tgt   [2048];
    bit m_known = 0;
    int m_left  = 0;
    int e_taken1 = 0, e_taken2 = 0, e_tgt1 = 0, e_tgt2 = 0;

    always @(posedge CLK) begin
        int a, i1, i2;
        if (RST) begin
            m_known = 1;
            m_left  = 2048;
            for (int k = 0; k < 2048; k++) begin
                m_valid[k] = 0; m_cnt[k] = 0; m_tgt[k] = 0;
            end
            e_taken1 = 0; e_taken2 = 0; e_tgt1 = 0; e_tgt2 = 0;
        end else if (m_known) begin
            if (m_left > 0) begin
                m_left = m_left - 1;
                e_taken1 = 0; e_taken2 = 0; e_tgt1 = 0; e_tgt2 = 0;
            end else begin
                if (W_EN) begin
                    a = int'(W_ADDR);
                    if (W_DATA[14]) begin
                        m_valid[a] = 1; m_cnt[a] = 3; m_tgt[a] = int'(W_DATA[12:0]);
                    end else if (!m_valid[a]) begin
                        m_valid[a] = 1;
                        m_cnt[a]   = W_DATA[15] ? 2 : 1;
                        m_tgt[a]   = W_DATA[15] ? int'(W_DATA[12:0]) : 0;
                    end else if (W_DATA[15]) begin
                        m_cnt[a] = (m_cnt[a] + 1 > 3) ? 3 : m_cnt[a] + 1;
                        m_tgt[a] = int'(W_DATA[12:0]);
                    end else begin
                        m_cnt[a] = (m_cnt[a] - 1 < 0) ? 0 : m_cnt[a] - 1;
                    end
                end
                if (!STALL) begin
                    i1 = int'(RD_PC1) / 4;
                    i2 = int'(RD_PC2) / 4;
                    e_taken1 = (m_valid[i1] && m_cnt[i1] >= 2) ? 1 : 0;
                    e_taken2 = (m_valid[i2] && m_cnt[i2] >= 2) ? 1 : 0;
                    e_tgt1   = m_tgt[i1];
                    e_tgt2   = m_tgt[i2];
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (m_known) begin
            checks = checks + 1;
            if (BUSY !== (m_left > 0) || PRED_TAKEN1 !== e_taken1[0] || PRED_TAKEN2 !== e_taken2[0] ||
                PRED_TGT1 !== e_tgt1[12:0] || PRED_TGT2 !== e_tgt2[12:0]) begin
                errors = errors + 1;
                $display("FAIL model t=%0t busy=%b/%0d tk1=%b/%0d tg1=%h/%h tk2=%b/%0d tg2=%h/%h",
                         $time, BUSY, m_left > 0, PRED_TAKEN1, e_taken1, PRED_TGT1, e_tgt1[12:0],
                         PRED_TAKEN2, e_taken2, PRED_TGT2, e_tgt2[12:0]);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // counts consecutive BUSY cycles starting right after a reset edge; W_EN dropped after a while
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!BUSY) break;
            n++;
            if (n == 100) W_EN = 1'b0;
            tick();
        end
    endtask

    int n;
    bit exp_seq [7] = '{1, 1, 1, 1, 0, 0, 0};

    initial begin
        // 1: reset sweep then everything reads as empty
        RST = 1'b1; tick(); RST = 1'b0;
        count_busy(n);
        chk("busy_len_1", n, 2048);
        RD_PC1 = 13'h1FFC; RD_PC2 = 13'h0040; tick();
        chk("empty_tk1", int'(PRED_TAKEN1), 0);
        chk("empty_tg1", int'(PRED_TGT1), 0);
        chk("empty_tk2", int'(PRED_TAKEN2), 0);

        // 2: taken update then lookup
        W_EN = 1'b1; W_ADDR = 11'h010; W_DATA = 16'h8200; tick();
        W_EN = 1'b0; RD_PC1 = 13'h0040; tick();
        chk("upd_tk1", int'(PRED_TAKEN1), 1);
        chk("upd_tg1", int'(PRED_TGT1), 'h200);

        // 3: saturating counter via bypassed reads after each update
        RD_PC1 = 13'h0080; RD_PC2 = 13'h0083; W_ADDR = 11'h020;
        for (int k = 0; k < 7; k++) begin
            W_EN = 1'b1; W_DATA = (k < 3) ? 16'h8123 : 16'h0000; tick();
            chk("sat_tk1", int'(PRED_TAKEN1), int'(exp_seq[k]));
        end
        W_EN = 1'b0;
        chk("sat_tg1", int'(PRED_TGT1), 'h123);
        chk("alias_tk2", int'(PRED_TAKEN2), int'(PRED_TAKEN1));

        // 4: jump update bypassed to both slots
        W_EN = 1'b1; W_ADDR = 11'h005; W_DATA = 16'h4AAA;
        RD_PC1 = 13'h0014; RD_PC2 = 13'h0014; tick();
        W_EN = 1'b0;
        chk("byp_tk1", int'(PRED_TAKEN1), 1);
        chk("byp_tg1", int'(PRED_TGT1), 'hAAA);
        chk("byp_tk2", int'(PRED_TAKEN2), 1);
        chk("byp_tg2", int'(PRED_TGT2), 'hAAA);

        // 5: stall holds outputs while an update to the held index commits
        STALL = 1'b1; RD_PC1 = 13'h0100; W_EN = 1'b1; W_ADDR = 11'h005; W_DATA = 16'h8555; tick();
        W_EN = 1'b0; RD_PC1 = 13'h0040; tick();
        RD_PC1 = 13'h0080; tick();
        chk("stall_tg1", int'(PRED_TGT1), 'hAAA);
        chk("stall_tk1", int'(PRED_TAKEN1), 1);
        STALL = 1'b0; RD_PC1 = 13'h0014; tick();
        chk("post_tg1", int'(PRED_TGT1), 'h555);
        chk("post_tk1", int'(PRED_TAKEN1), 1);

        // 6: reset mid-sweep with an update pending the whole time
        RST = 1'b1; tick(); RST = 1'b0;
        W_EN = 1'b1; W_ADDR = 11'h030; W_DATA = 16'h8111;
        repeat (999) tick();
        chk("mid_busy", int'(BUSY), 1);
        RST = 1'b1; tick(); RST = 1'b0;
        count_busy(n);
        chk("busy_len_2", n, 2048);
        W_EN = 1'b0; RD_PC1 = 13'h00C0; RD_PC2 = 13'h0014; tick();
        chk("drop_tk1", int'(PRED_TAKEN1), 0);
        chk("drop_tg1", int'(PRED_TGT1), 0);
        chk("clr_tg2", int'(PRED_TGT2), 0);

        // first not-taken update to an empty entry: weakly not taken, target zero
        W_EN = 1'b1; W_ADDR = 11'h030; W_DATA = 16'h0777; tick();
        W_EN = 1'b1; W_DATA = 16'h8777; tick();
        W_EN = 1'b0; tick();
        chk("wnt_tk1", int'(PRED_TAKEN1), 1);
        chk("wnt_tg1", int'(PRED_TGT1), 'h777);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
